// File: rtl/ex_mem_if.sv
// ex_mem_if: bundle of the signals between the EX stage, the EX/MEM
// pipeline register and the MEM stage.
//   stall/flush            : pipeline control into the register
//   ex_*, hilo_temp_i, cnt_i : EX results and multiply-accumulate state in
//   mem_*, mem_valid       : registered results towards MEM
//   hilo_temp_o, cnt_o     : multiply-accumulate state fed back to EX
// The slave modport is the register's view; master is the driver's view.
interface ex_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [5:0]          stall;
  logic                flush;
  logic                ex_we;
  logic [ADDR_W-1:0]   ex_waddr;
  logic [DATA_W-1:0]   ex_wdata;
  logic                ex_we_hilo;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic [2*DATA_W-1:0] hilo_temp_i;
  logic [1:0]          cnt_i;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_we_hilo;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic                mem_valid;
  logic [2*DATA_W-1:0] hilo_temp_o;
  logic [1:0]          cnt_o;

  modport slave (
    input  stall, flush, ex_we, ex_waddr, ex_wdata, ex_we_hilo, ex_hi,
           ex_lo, hilo_temp_i, cnt_i,
    output mem_we, mem_waddr, mem_wdata, mem_we_hilo, mem_hi, mem_lo,
           mem_valid, hilo_temp_o, cnt_o
  );

  modport master (
    output stall, flush, ex_we, ex_waddr, ex_wdata, ex_we_hilo, ex_hi,
           ex_lo, hilo_temp_i, cnt_i,
    input  mem_we, mem_waddr, mem_wdata, mem_we_hilo, mem_hi, mem_lo,
           mem_valid, hilo_temp_o, cnt_o
  );
endinterface

// File: rtl/ex_mem.sv
// ex_mem: EX/MEM pipeline register of the five-stage MIPS core.
// Captures the EX register and HI/LO write-back results each cycle the EX
// stage advances, inserts a bubble when EX stalls but MEM proceeds, holds
// when both stall, and zeroes everything on reset or exception flush. It
// also parks the 64-bit partial product and the cycle counter used by the
// two-cycle multiply-accumulate instructions while EX stalls itself.
// Ports:
//   clk  : core clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ex_mem_if slave (stall/flush, ex_* in, mem_* and feedback out)
module ex_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic      clk,
  input  logic      rst,
  ex_mem_if.slave   bus
);

  logic                mem_we_reg;
  logic [ADDR_W-1:0]   mem_waddr_reg;
  logic [DATA_W-1:0]   mem_wdata_reg;
  logic                mem_we_hilo_reg;
  logic [DATA_W-1:0]   mem_hi_reg;
  logic [DATA_W-1:0]   mem_lo_reg;
  logic                mem_valid_reg;
  logic [2*DATA_W-1:0] hilo_temp_reg;
  logic [1:0]          cnt_reg;

  logic stall_ex;
  logic stall_mem;

  assign stall_ex  = bus.stall[3];
  assign stall_mem = bus.stall[4];

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      mem_we_reg      <= 1'b0;
      mem_waddr_reg   <= '0;
      mem_wdata_reg   <= '0;
      mem_we_hilo_reg <= 1'b0;
      mem_hi_reg      <= '0;
      mem_lo_reg      <= '0;
      mem_valid_reg   <= 1'b0;
      hilo_temp_reg   <= '0;
      cnt_reg         <= 2'b00;
    end else if (!stall_ex) begin
      // EX advances (the illegal stall_mem-only pattern lands here too);
      // any parked accumulate state has just been consumed by EX.
      mem_we_reg      <= bus.ex_we;
      mem_waddr_reg   <= bus.ex_waddr;
      mem_wdata_reg   <= bus.ex_wdata;
      mem_we_hilo_reg <= bus.ex_we_hilo;
      mem_hi_reg      <= bus.ex_hi;
      mem_lo_reg      <= bus.ex_lo;
      mem_valid_reg   <= 1'b1;
      hilo_temp_reg   <= '0;
      cnt_reg         <= 2'b00;
    end else if (!stall_mem) begin
      // Bubble: MEM receives a NOP while EX keeps its partial product here.
      mem_we_reg      <= 1'b0;
      mem_waddr_reg   <= '0;
      mem_wdata_reg   <= '0;
      mem_we_hilo_reg <= 1'b0;
      mem_hi_reg      <= '0;
      mem_lo_reg      <= '0;
      mem_valid_reg   <= 1'b0;
      hilo_temp_reg   <= bus.hilo_temp_i;
      cnt_reg         <= bus.cnt_i;
    end
    // Both stalled: every register holds.
  end

  assign bus.mem_we      = mem_we_reg;
  assign bus.mem_waddr   = mem_waddr_reg;
  assign bus.mem_wdata   = mem_wdata_reg;
  assign bus.mem_we_hilo = mem_we_hilo_reg;
  assign bus.mem_hi      = mem_hi_reg;
  assign bus.mem_lo      = mem_lo_reg;
  assign bus.mem_valid   = mem_valid_reg;
  assign bus.hilo_temp_o = hilo_temp_reg;
  assign bus.cnt_o       = cnt_reg;

endmodule

// File: tb/tb_ex_mem.sv
module tb_ex_mem;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   illegal_seen = 0;

  always #5 clk = ~clk;

  ex_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ex_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference state: what the MEM side should see after each edge.
  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we_hilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        valid;
    logic [63:0] temp;
    logic [1:0]  cnt;
  } slot_t;

  slot_t model;

  // Monotonic stall vector: MEM stalled while EX runs is illegal.
  always @(posedge clk) begin
    if (!rst && bus.stall[4] && !bus.stall[3]) begin
      illegal_seen++;
      $display("note: illegal stall vector %b at %0t", bus.stall, $time);
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic slot_t zero_slot();
    slot_t z;
    z.we = 0; z.waddr = 0; z.wdata = 0; z.we_hilo = 0; z.hi = 0; z.lo = 0;
    z.valid = 0; z.temp = 0; z.cnt = 0;
    return z;
  endfunction

  // Next slot from the operating rules, applied to the values present at the edge.
  function automatic slot_t next_slot(slot_t cur);
    slot_t n;
    n = cur;
    if (rst || bus.flush) begin
      n = zero_slot();
    end else if (bus.stall[3] && bus.stall[4]) begin
      n = cur;
    end else if (bus.stall[3]) begin
      n = zero_slot();
      n.temp = bus.hilo_temp_i;
      n.cnt  = bus.cnt_i;
    end else begin
      n.we = bus.ex_we; n.waddr = bus.ex_waddr; n.wdata = bus.ex_wdata;
      n.we_hilo = bus.ex_we_hilo; n.hi = bus.ex_hi; n.lo = bus.ex_lo;
      n.valid = 1; n.temp = 0; n.cnt = 0;
    end
    return n;
  endfunction

  task automatic randomize_ex();
    bus.ex_we       = 1'($urandom);
    bus.ex_waddr    = 5'($urandom);
    bus.ex_wdata    = $urandom;
    bus.ex_we_hilo  = 1'($urandom);
    bus.ex_hi       = $urandom;
    bus.ex_lo       = $urandom;
    bus.hilo_temp_i = {$urandom, $urandom};
    bus.cnt_i       = 2'($urandom);
  endtask

  // One clock: update the model with the values at the edge, then compare.
  task automatic cycle(input string tag);
    slot_t n;
    n = next_slot(model);
    @(posedge clk);
    #1;
    model = n;
    check({tag, ".we"},      64'(bus.mem_we),      64'(model.we));
    check({tag, ".waddr"},   64'(bus.mem_waddr),   64'(model.waddr));
    check({tag, ".wdata"},   64'(bus.mem_wdata),   64'(model.wdata));
    check({tag, ".we_hilo"}, 64'(bus.mem_we_hilo), 64'(model.we_hilo));
    check({tag, ".hi"},      64'(bus.mem_hi),      64'(model.hi));
    check({tag, ".lo"},      64'(bus.mem_lo),      64'(model.lo));
    check({tag, ".valid"},   64'(bus.mem_valid),   64'(model.valid));
    check({tag, ".temp"},    bus.hilo_temp_o,      model.temp);
    check({tag, ".cnt"},     64'(bus.cnt_o),       64'(model.cnt));
    $display("%-8s rst=%b fl=%b st=%b -> we=%b wa=%0d wd=%h v=%b cnt=%0d tmp=%h",
             tag, rst, bus.flush, bus.stall, bus.mem_we, bus.mem_waddr,
             bus.mem_wdata, bus.mem_valid, bus.cnt_o, bus.hilo_temp_o);
  endtask

  initial begin
    model = zero_slot();
    // Reset with every input nonzero.
    rst = 1; bus.flush = 0; bus.stall = 6'b111111;
    bus.ex_we = 1; bus.ex_waddr = 5'd31; bus.ex_wdata = 32'hDEADBEEF;
    bus.ex_we_hilo = 1; bus.ex_hi = 32'hFFFF_FFFF; bus.ex_lo = 32'h1;
    bus.hilo_temp_i = 64'hFFFF_0000_FFFF_0000; bus.cnt_i = 2'b01;
    cycle("reset0");
    check("reset.wdata", 64'(bus.mem_wdata), 64'h0);
    check("reset.cnt", 64'(bus.cnt_o), 64'h0);
    bus.stall = 6'b000000;
    cycle("reset1");
    rst = 0; bus.stall = 6'b001000;
    cycle("postrst");
    check("postrst.valid", 64'(bus.mem_valid), 64'h0);

    // Capture.
    bus.stall = 0; bus.ex_we = 1; bus.ex_waddr = 5'd3; bus.ex_wdata = 32'h12345678;
    bus.ex_we_hilo = 1; bus.ex_hi = 32'hA; bus.ex_lo = 32'hB;
    cycle("capture");
    check("capture.wdata", 64'(bus.mem_wdata), 64'h12345678);
    check("capture.waddr", 64'(bus.mem_waddr), 64'd3);
    check("capture.valid", 64'(bus.mem_valid), 64'h1);

    // Bubble parks the accumulate state, then EX finishes.
    bus.stall = 6'b001111; bus.cnt_i = 2'b01; bus.hilo_temp_i = 64'h0000_0001_0000_0002;
    cycle("bubble");
    check("bubble.cnt", 64'(bus.cnt_o), 64'h1);
    check("bubble.temp", bus.hilo_temp_o, 64'h0000_0001_0000_0002);
    check("bubble.we", 64'(bus.mem_we), 64'h0);
    bus.stall = 0; bus.ex_wdata = 32'hCAFE_0001; bus.cnt_i = 2'b00;
    cycle("maddfin");
    check("maddfin.cnt", 64'(bus.cnt_o), 64'h0);
    check("maddfin.temp", bus.hilo_temp_o, 64'h0);
    check("maddfin.wdata", 64'(bus.mem_wdata), 64'hCAFE_0001);

    // Hold keeps the loaded slot while inputs change.
    bus.ex_wdata = 32'h55; bus.stall = 0;
    cycle("load55");
    bus.stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      randomize_ex();
      cycle("hold");
      check("hold.wdata", 64'(bus.mem_wdata), 64'h55);
      check("hold.valid", 64'(bus.mem_valid), 64'h1);
    end

    // Flush during a bubble.
    bus.stall = 6'b001111; bus.cnt_i = 2'b01; bus.flush = 1;
    cycle("flush");
    check("flush.cnt", 64'(bus.cnt_o), 64'h0);
    check("flush.valid", 64'(bus.mem_valid), 64'h0);
    bus.flush = 0;

    // Illegal stall pattern behaves as capture and is flagged.
    randomize_ex(); bus.ex_wdata = 32'h0BAD_0BAD; bus.stall = 6'b010000;
    cycle("illegal");
    check("illegal.wdata", 64'(bus.mem_wdata), 64'h0BAD_0BAD);
    check("illegal.flagged", 64'(illegal_seen), 64'd1);

    // Randomized legal traffic, occasional flush and reset, including
    // reset asserted mid accumulate.
    for (int i = 0; i < 200; i++) begin
      int r;
      randomize_ex();
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3: bus.stall = 6'b000000;
        4, 5, 6:    bus.stall = {2'b00, 1'b1, 3'($urandom)};
        default:    bus.stall = {1'($urandom), 2'b11, 3'($urandom)};
      endcase
      bus.flush = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 29) == 0);
      cycle("rand");
    end
    rst = 0; bus.flush = 0;
    check("rand.noillegal", 64'(illegal_seen), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
